// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: owner codes, FSM encodings
// and default tuning values.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned DEF_TIMEOUT      = 1023;
    localparam int unsigned STARVE_W         = 3;
    localparam int unsigned WDOG_W           = 10;

    typedef enum logic [1:0] {
        OWN_D    = 2'd0,
        OWN_U    = 2'd1,
        OWN_I    = 2'd2,
        OWN_NONE = 2'd3
    } owner_t;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_WAIT  = 4'b0100,
        ST_DONE  = 4'b1000
    } state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: starved uncache/icache first, then the
// fixed dcache > uncache > icache order.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   req_d,
    input  logic   req_u,
    input  logic   req_i,
    input  logic   starve_u,
    input  logic   starve_i,
    output owner_t pick_c,
    output logic   pick_vld_c
);

    always_comb begin
        pick_c = OWN_NONE;
        if (req_u && starve_u)      pick_c = OWN_U;
        else if (req_i && starve_i) pick_c = OWN_I;
        else if (req_d)             pick_c = OWN_D;
        else if (req_u)             pick_c = OWN_U;
        else if (req_i)             pick_c = OWN_I;
    end

    assign pick_vld_c = (pick_c != OWN_NONE);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates dcache/uncache/icache onto one memory port, sequences the
// downstream start/done handshake and guards WAIT with a watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_d,
    input  logic       req_u,
    input  logic       req_i,
    output logic       gnt_d,
    output logic       gnt_u,
    output logic       gnt_i,
    output logic       done_d,
    output logic       done_u,
    output logic       done_i,
    output logic       m_start,
    output logic [1:0] m_sel,
    input  logic       m_done,
    output logic       err
);

    state_t              state;
    logic [STARVE_W-1:0] cnt_u;
    logic [STARVE_W-1:0] cnt_i;
    logic [WDOG_W-1:0]   wdog;
    owner_t              pick;
    logic                pick_vld;
    logic                starve_u;
    logic                starve_i;
    logic                wdog_exp;

    assign starve_u = (cnt_u == STARVE_W'(STARVE_LIMIT));
    assign starve_i = (cnt_i == STARVE_W'(STARVE_LIMIT));
    assign wdog_exp = (wdog == WDOG_W'(TIMEOUT - 1));

    arb_pick u_arb_pick (
        .req_d      (req_d),
        .req_u      (req_u),
        .req_i      (req_i),
        .starve_u   (starve_u),
        .starve_i   (starve_i),
        .pick_c     (pick),
        .pick_vld_c (pick_vld)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            gnt_d   <= 1'b0;
            gnt_u   <= 1'b0;
            gnt_i   <= 1'b0;
            done_d  <= 1'b0;
            done_u  <= 1'b0;
            done_i  <= 1'b0;
            m_start <= 1'b0;
            m_sel   <= OWN_NONE;
            err     <= 1'b0;
            cnt_u   <= '0;
            cnt_i   <= '0;
            wdog    <= '0;
        end else begin
            m_start <= 1'b0;
            done_d  <= 1'b0;
            done_u  <= 1'b0;
            done_i  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    m_sel <= OWN_NONE;
                    if (pick_vld) begin
                        state   <= ST_START;
                        m_sel   <= pick;
                        m_start <= 1'b1;
                        gnt_d   <= (pick == OWN_D);
                        gnt_u   <= (pick == OWN_U);
                        gnt_i   <= (pick == OWN_I);
                        // Losers still requesting age toward promotion; the winner resets
                        if (pick == OWN_U)
                            cnt_u <= '0;
                        else if (req_u && !starve_u)
                            cnt_u <= cnt_u + STARVE_W'(1);
                        if (pick == OWN_I)
                            cnt_i <= '0;
                        else if (req_i && !starve_i)
                            cnt_i <= cnt_i + STARVE_W'(1);
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                    wdog  <= '0;
                end
                ST_WAIT: begin
                    // m_done takes precedence over a coincident watchdog expiry
                    if (m_done || wdog_exp) begin
                        state  <= ST_DONE;
                        done_d <= gnt_d;
                        done_u <= gnt_u;
                        done_i <= gnt_i;
                        gnt_d  <= 1'b0;
                        gnt_u  <= 1'b0;
                        gnt_i  <= 1'b0;
                        if (!m_done) err <= 1'b1;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    m_sel <= OWN_NONE;
                end
                default: begin
                    state <= ST_IDLE;
                    m_sel <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios push expected
// grants/completions, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req_d, req_u, req_i;
    logic       gnt_d, gnt_u, gnt_i;
    logic       done_d, done_u, done_i;
    logic       m_start;
    logic [1:0] m_sel;
    logic       m_done;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] exp_start_q[$];
    logic [3:0] exp_done_q[$];

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req_d   (req_d),
        .req_u   (req_u),
        .req_i   (req_i),
        .gnt_d   (gnt_d),
        .gnt_u   (gnt_u),
        .gnt_i   (gnt_i),
        .done_d  (done_d),
        .done_u  (done_u),
        .done_i  (done_i),
        .m_start (m_start),
        .m_sel   (m_sel),
        .m_done  (m_done),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] onehot(input logic [1:0] s);
        case (s)
            2'd0:    return 3'b100;
            2'd1:    return 3'b010;
            2'd2:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full output vector {gnt, done, m_start, m_sel, err}; idle/reset value is 10'b000_000_0_11_0
    task automatic chk_idle(input string name);
        chk(name, 32'({gnt_d, gnt_u, gnt_i, done_d, done_u, done_i, m_start, m_sel, err}),
            32'(10'b000_000_0_11_0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] sel, input logic dn_err, input bit with_done);
        exp_start_q.push_back(sel);
        if (with_done) exp_done_q.push_back({onehot(sel), dn_err});
    endtask

    task automatic wait_start();
        int k;
        for (k = 0; k < 50; k++) begin
            if (m_start) break;
            tick();
        end
        if (k == 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_start: m_start never rose within 50 cycles at %0t", $time);
        end
    endtask

    // Serve one grant: m_done after lat cycles past START, then drop the listed requests
    task automatic txn(input int lat, input logic [2:0] drop);
        wait_start();
        repeat (lat) tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
        if (drop[2]) req_d = 1'b0;
        if (drop[1]) req_u = 1'b0;
        if (drop[0]) req_i = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) tick();
        chk_idle("reset_values");
        rstn = 1'b1;
        tick();
    endtask

    // Monitor: every m_start and every done pulse must match the next expected entry
    always @(negedge clk) begin
        if (rstn) begin
            if (m_start) begin
                n_tests++;
                if (exp_start_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_start: unexpected m_start m_sel=%0d at %0t", m_sel, $time);
                end else begin
                    logic [1:0] e;
                    e = exp_start_q.pop_front();
                    if (m_sel !== e || {gnt_d, gnt_u, gnt_i} !== onehot(e)) begin
                        n_fail++;
                        $display("FAIL sb_start: m_sel=%0d gnt=%b expected m_sel=%0d gnt=%b at %0t",
                                 m_sel, {gnt_d, gnt_u, gnt_i}, e, onehot(e), $time);
                    end
                end
            end
            if (done_d || done_u || done_i) begin
                n_tests++;
                if (exp_done_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_done: unexpected done=%b at %0t", {done_d, done_u, done_i}, $time);
                end else begin
                    logic [3:0] e;
                    e = exp_done_q.pop_front();
                    if ({done_d, done_u, done_i, err} !== e || {gnt_d, gnt_u, gnt_i} !== 3'b000) begin
                        n_fail++;
                        $display("FAIL sb_done: done,err=%b gnt=%b expected done,err=%b gnt=000 at %0t",
                                 {done_d, done_u, done_i, err}, {gnt_d, gnt_u, gnt_i}, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rstn = 1'b0; req_d = 1'b0; req_u = 1'b0; req_i = 1'b0; m_done = 1'b0;
        tick();
        do_reset();

        // Single dcache request with exact cycle timeline
        req_d = 1'b1;
        push(OWN_D, 1'b0, 1'b1);
        tick();
        chk("s1_start_c1", 32'({m_start, m_sel, gnt_d}), 32'({1'b1, 2'd0, 1'b1}));
        tick();
        chk("s1_start_c2", 32'({m_start, gnt_d}), 32'({1'b0, 1'b1}));
        repeat (3) tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("s1_done_c6", 32'({done_d, gnt_d}), 32'({1'b1, 1'b0}));
        req_d = 1'b0;
        tick();
        chk_idle("s1_idle_c7");

        // Stray m_done in IDLE
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk_idle("stray_mdone_c1");
        tick();
        chk_idle("stray_mdone_c2");

        // Simultaneous requests: dcache, uncache, icache in turn
        do_reset();
        req_d = 1'b1; req_u = 1'b1; req_i = 1'b1;
        push(OWN_D, 1'b0, 1'b1);
        push(OWN_U, 1'b0, 1'b1);
        push(OWN_I, 1'b0, 1'b1);
        txn(2, 3'b100);
        txn(1, 3'b010);
        txn(3, 3'b001);
        tick();
        chk_idle("simul_idle");

        // Starvation: icache wins the fifth arbitration against continuous dcache
        do_reset();
        req_d = 1'b1; req_i = 1'b1;
        for (int n = 0; n < 4; n++) push(OWN_D, 1'b0, 1'b1);
        push(OWN_I, 1'b0, 1'b1);
        push(OWN_D, 1'b0, 1'b1);
        for (int n = 0; n < 4; n++) txn(1, 3'b000);
        txn(1, 3'b001);
        txn(1, 3'b100);
        tick();
        chk_idle("starve_idle");

        // m_done coinciding with watchdog expiry: normal completion, err stays 0
        do_reset();
        req_i = 1'b1;
        push(OWN_I, 1'b0, 1'b1);
        wait_start();
        repeat (16) tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("tie_done_err", 32'({done_i, err}), 32'({1'b1, 1'b0}));
        req_i = 1'b0;
        repeat (2) tick();

        // Timeout: done 16 cycles after WAIT entry with err set, err sticky
        req_u = 1'b1;
        push(OWN_U, 1'b1, 1'b1);
        wait_start();
        repeat (16) tick();
        chk("to_before", 32'({done_u, err, gnt_u}), 32'({1'b0, 1'b0, 1'b1}));
        tick();
        chk("to_done", 32'({done_u, err, gnt_u}), 32'({1'b1, 1'b1, 1'b0}));
        req_u = 1'b0;
        repeat (5) tick();
        chk("to_sticky", 32'(err), 32'(1'b1));
        req_d = 1'b1;
        push(OWN_D, 1'b1, 1'b1);
        txn(2, 3'b100);
        chk("to_sticky_after_txn", 32'(err), 32'(1'b1));
        do_reset();
        chk("to_err_cleared", 32'(err), 32'(1'b0));

        // Reset during WAIT abandons the transaction, then uncache is served normally
        req_u = 1'b1;
        push(OWN_U, 1'b0, 1'b0);
        wait_start();
        repeat (3) tick();
        chk("mid_in_wait", 32'({gnt_u, m_sel}), 32'({1'b1, 2'd1}));
        req_u = 1'b0;
        rstn = 1'b0;
        tick();
        chk_idle("mid_reset_c1");
        rstn = 1'b1;
        tick();
        chk_idle("mid_after_c1");
        tick();
        chk_idle("mid_after_c2");
        req_u = 1'b1;
        push(OWN_U, 1'b0, 1'b1);
        txn(2, 3'b010);
        tick();
        chk_idle("mid_final_idle");

        repeat (3) tick();
        chk("sb_start_drained", 32'(exp_start_q.size()), 32'd0);
        chk("sb_done_drained", 32'(exp_done_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of grants lost by a waiting low-priority requester before it is promoted to top priority.
REQ-002 Parameter TIMEOUT, default 1023: maximum number of cycles in WAIT before the transaction is aborted.
REQ-003 Port clk  input  1  clock; all logic updates on the rising edge.
REQ-004 Port rstn  input  1  reset, synchronous, active-low.
REQ-005 Ports req_d, req_u, req_i  input  1 each  level request from dcache, uncache and icache.
REQ-006 Ports gnt_d, gnt_u, gnt_i  output  1 each  level grant, high while the requester owns the memory port.
REQ-007 Ports done_d, done_u, done_i  output  1 each  one-cycle completion pulse to the owner.
REQ-008 Port m_start  output  1  one-cycle pulse that starts the downstream AXI sequencer.
REQ-009 Port m_sel  output  2  owner code: 0 = dcache, 1 = uncache, 2 = icache, 3 = none.
REQ-010 Port m_done  input  1  completion pulse from the downstream sequencer.
REQ-011 Port err  output  1  sticky timeout flag.

Function
REQ-012 The block SHALL implement a one-hot FSM with states IDLE, START, WAIT and DONE.
REQ-013 IDLE: when any req is high, the block SHALL latch the winner into m_sel/gnt_x and move to START on the next edge; otherwise it SHALL stay in IDLE with m_sel = 3.
REQ-014 Base priority SHALL be dcache > uncache > icache.
REQ-015 A starved requester, i.e. one whose starve counter equals STARVE_LIMIT, SHALL beat non-starved requesters; if both uncache and icache are starved, uncache wins.
REQ-016 uncache and icache SHALL each have a 3-bit starve counter that:
  - increments, saturating at STARVE_LIMIT, on each grant to another requester while its own req is high;
  - clears when that requester is granted.
REQ-017 START: m_start SHALL be high for exactly this one cycle, then the FSM moves to WAIT.
REQ-018 WAIT: the block SHALL hold gnt_x and m_sel stable until m_done = 1, then move to DONE.
REQ-019 DONE: done_x SHALL pulse for one cycle, gnt_x SHALL be low, and the next state SHALL be IDLE.
REQ-020 Minimum latency: req high at edge N -> m_start high in cycle N+1 -> done_x in the cycle after m_done is sampled.
REQ-021 A requester SHALL deassert req on the edge that samples its done_x high.
REQ-022 Deassertion of req while granted SHALL be ignored; the transaction completes.
REQ-023 req changes during START, WAIT or DONE SHALL NOT alter m_sel; arbitration happens only in IDLE.
REQ-024 m_done outside WAIT SHALL be ignored.
REQ-025 A 10-bit watchdog SHALL count cycles in WAIT and clear on entry to WAIT.
REQ-026 When the watchdog reaches TIMEOUT without m_done, the block SHALL set err and move to DONE; done_x pulses normally.
REQ-027 If m_done and the timeout occur in the same cycle, m_done SHALL win and err SHALL stay unchanged.

Reset
REQ-028 While rstn = 0 at an edge, the block SHALL force:
  - FSM to IDLE;
  - gnt_* = 0, done_* = 0, m_start = 0, m_sel = 3, err = 0;
  - starve counters and watchdog to 0.
REQ-029 Reset during WAIT SHALL abandon the transaction with no done pulse.

Structure
REQ-030 The owner codes, the FSM state encodings and the default STARVE_LIMIT/TIMEOUT values SHALL live in the shared defines package.
REQ-031 The priority and starvation selection SHALL be a combinational sub-module, arb_pick, instantiated once.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
  - Single dcache request: req_d = 1 at cycle 0 -> m_start at 1 with m_sel = 0; m_done at 5 -> done_d at 6, gnt_d low at 6, FSM in IDLE at 7.
  - Simultaneous requests: req_d, req_u and req_i all high -> grant order dcache, uncache, icache.
  - Starvation: req_d and req_i high continuously, STARVE_LIMIT = 4 -> icache granted on the fifth arbitration, after 4 dcache grants.
  - Timeout: no m_done with TIMEOUT = 16 -> err = 1 and done_x pulse 16 cycles after WAIT entry; err stays 1 until reset.
  - Mid-operation reset: rstn low during WAIT -> all outputs at reset values the next cycle and no done pulse; a new req_u afterwards is served normally.
  - Stray m_done: m_done pulsed in IDLE -> no state change and no done pulse.
